// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
//
// Sequential bridge between the MEM-stage byte-lane formatter and an SRAM-like
// data bus with a req / addr_ok / data_ok handshake. It accepts one load or
// store per instruction and issues exactly one bus transaction for it. The
// pipeline is stalled until the access completes. If other stall sources are
// still active at completion, the read word is held (HOLD state) until the
// instruction leaves MEM.
//
// Parameters
//   ADDR_W        address width on both sides
//   DATA_W        data width (only 32 is supported; byte strobes are 4 bits)
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   cpu_en        MEM stage holds a valid load/store this cycle
//   cpu_sel       write byte strobe, 0000 = load
//   cpu_size      0 byte, 1 half, 2 word
//   cpu_addr      byte address
//   cpu_wdata     lane-replicated store data
//   longest_stall OR of every other pipeline stall source
//   cpu_rdata     raw read word to the load formatter
//   cpu_stall     stall request from this block (combinational)
//   data_*        bus side: req/wr/size/addr/wdata/wstrb out,
//                 addr_ok/data_ok/rdata in
//   stall_cnt     count of cycles with cpu_stall=1
//
// Optional build macro
//   DSRAM_STALL_CNT_EN  when defined, stall_cnt is a free-running 32-bit
//                       counter of stalled cycles; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_en,
    input  logic [3:0]        cpu_sel,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,

    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic              done;

    // The access finishes this cycle: either both handshakes land together
    // while the request is still up, or data_ok arrives after addr_ok.
    // data_ok without addr_ok in ADDR is not a completion.
    assign done = ((state == S_ADDR) && data_addr_ok && data_data_ok) ||
                  ((state == S_DATA) && data_data_ok);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cpu_en) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_nxt = longest_stall ? S_HOLD : S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (data_data_ok) begin
                    state_nxt = longest_stall ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                // The instruction leaves MEM on the edge where the other
                // stalls drop, so returning to IDLE cannot reissue it.
                if (!longest_stall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic (combinational)
    // ---------------------------------------------------------------------
    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            S_IDLE:  cpu_stall = cpu_en;
            S_ADDR:  cpu_stall = !(data_addr_ok && data_data_ok);
            S_DATA:  cpu_stall = !data_data_ok;
            default: cpu_stall = 1'b0;
        endcase
        // On the completing cycle, pass the bus word straight through so
        // the pipeline can advance on the same edge.
        cpu_rdata = done ? data_rdata : rdata_q;
    end

    // ---------------------------------------------------------------------
    // Bus-side request registers and read-data holding register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            data_wstrb <= 4'd0;
            rdata_q    <= '0;
        end else begin
            if ((state == S_IDLE) && cpu_en) begin
                data_req   <= 1'b1;
                data_wr    <= |cpu_sel;
                data_size  <= cpu_size;
                data_addr  <= cpu_addr;
                data_wdata <= cpu_wdata;
                data_wstrb <= cpu_sel;
            end else if ((state == S_ADDR) && data_addr_ok) begin
                // Drop the request on the edge where the address is
                // accepted. The address, data and strobe fields stay
                // unchanged until the next access.
                data_req <= 1'b0;
            end
            // Stores latch the acknowledge-cycle bus data as well. This
            // value is unused for stores.
            if (done) begin
                rdata_q <= data_rdata;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stalled-cycle counter
    // ---------------------------------------------------------------------
`ifdef DSRAM_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt <= 32'd0;
        end else if (cpu_stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bridge
//
// Directed self-checking bench for data_sram_bridge. Inputs change 1 ns after
// the rising edge. Outputs are sampled on the falling edge, so combinational
// outputs reflect the inputs of the current cycle. Each scenario task begins
// and ends at posedge+1.
// -----------------------------------------------------------------------------
module tb_data_sram_bridge;

    logic        clk;
    logic        resetn;
    logic        cpu_en;
    logic [3:0]  cpu_sel;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        longest_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_en        (cpu_en),
        .cpu_sel       (cpu_sel),
        .cpu_size      (cpu_size),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .longest_stall (longest_stall),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_en        = 1'b0;
        cpu_sel       = 4'd0;
        cpu_size      = 2'd0;
        cpu_addr      = 32'd0;
        cpu_wdata     = 32'd0;
        longest_stall = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'd0;
    endtask

    // Reset clears every registered output.
    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, cpu_rdata, stall_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b req=%b wr=%b size=%0d addr=%h wdata=%h wstrb=%b rdata=%h cnt=%0d, all required 0",
                     cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, cpu_rdata, stall_cnt);
        end
        step();
        resetn = 1'b1;
    endtask

    // Word load: addr_ok in cycle 1, data_ok in cycle 3.
    task automatic test_word_load();
        int stalls;
        stalls    = 0;
        cpu_en    = 1'b1;
        cpu_addr  = 32'h8000_1004;
        cpu_size  = 2'd2;
        cpu_sel   = 4'b0000;
        cpu_wdata = 32'd0;
        @(negedge clk);                        // cycle 0, IDLE
        stalls += int'(cpu_stall);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_c0: stall/req=%b, required 10", {cpu_stall, data_req});
        end
        step();
        data_addr_ok = 1'b1;
        @(negedge clk);                        // cycle 1, ADDR
        stalls += int'(cpu_stall);
        n_chk++;
        if ({cpu_stall, data_req, data_wr, data_size, data_addr} !== {1'b1, 1'b1, 1'b0, 2'd2, 32'h8000_1004}) begin
            n_fail++;
            $display("FAIL load_c1: stall=%b req=%b wr=%b size=%0d addr=%h, required 1 1 0 2 80001004",
                     cpu_stall, data_req, data_wr, data_size, data_addr);
        end
        step();
        data_addr_ok = 1'b0;
        @(negedge clk);                        // cycle 2, DATA
        stalls += int'(cpu_stall);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL load_c2: stall/req=%b, required 10", {cpu_stall, data_req});
        end
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);                        // cycle 3, completing
        stalls += int'(cpu_stall);
        n_chk++;
        if ({cpu_stall, data_req, cpu_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL load_c3: stall=%b req=%b rdata=%h, required 0 0 deadbeef", cpu_stall, data_req, cpu_rdata);
        end
        step();
        cpu_en       = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        @(negedge clk);                        // cycle 4, back in IDLE
        n_chk++;
        if ({cpu_stall, data_req, cpu_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL load_c4: stall=%b req=%b rdata=%h, required 0 0 deadbeef", cpu_stall, data_req, cpu_rdata);
        end
        n_chk++;
        if (stalls !== 3) begin
            n_fail++;
            $display("FAIL load_stall_cycles: %0d, required 3", stalls);
        end
        step();
    endtask

    // Byte store: both handshakes arrive in the first request cycle.
    task automatic test_byte_store();
        int stalls;
        stalls    = 0;
        cpu_en    = 1'b1;
        cpu_addr  = 32'h8000_0003;
        cpu_size  = 2'd0;
        cpu_sel   = 4'b1000;
        cpu_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        stalls += int'(cpu_stall);
        step();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        @(negedge clk);
        stalls += int'(cpu_stall);
        n_chk++;
        if ({data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata} !==
            {1'b1, 1'b1, 4'b1000, 2'd0, 32'h8000_0003, 32'h5A5A_5A5A}) begin
            n_fail++;
            $display("FAIL store_bus: req=%b wr=%b wstrb=%b size=%0d addr=%h wdata=%h, required 1 1 1000 0 80000003 5a5a5a5a",
                     data_req, data_wr, data_wstrb, data_size, data_addr, data_wdata);
        end
        step();
        cpu_en       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        stalls += int'(cpu_stall);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_after: stall/req=%b, required 00", {cpu_stall, data_req});
        end
        n_chk++;
        if (stalls !== 1) begin
            n_fail++;
            $display("FAIL store_stall_cycles: %0d, required 1", stalls);
        end
        step();
    endtask

    // Completion while longest_stall=1: HOLD keeps the word and does not reissue.
    task automatic test_hold();
        cpu_en    = 1'b1;
        cpu_addr  = 32'h8000_0010;
        cpu_size  = 2'd2;
        cpu_sel   = 4'b0000;
        step();                                // cycle 0 -> ADDR
        data_addr_ok = 1'b1;
        step();                                // cycle 1 -> DATA
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b1;
        data_rdata    = 32'h1234_5678;
        longest_stall = 1'b1;
        @(negedge clk);                        // cycle 2, completing
        n_chk++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL hold_complete: stall=%b rdata=%h, required 0 12345678", cpu_stall, cpu_rdata);
        end
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin      // 3 HOLD cycles, then the release cycle
            if (i == 3) longest_stall = 1'b0;
            @(negedge clk);
            n_chk++;
            if ({cpu_stall, data_req, cpu_rdata} !== {1'b0, 1'b0, 32'h1234_5678}) begin
                n_fail++;
                $display("FAIL hold_c%0d: stall=%b req=%b rdata=%h, required 0 0 12345678", i, cpu_stall, data_req, cpu_rdata);
            end
            step();
        end
        // Back in IDLE: a new instruction is accepted right away.
        cpu_addr = 32'h8000_0014;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_next_accept: stall/req=%b, required 10", {cpu_stall, data_req});
        end
        step();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BAD_CAFE;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req, data_addr, cpu_rdata} !== {1'b0, 1'b1, 32'h8000_0014, 32'h0BAD_CAFE}) begin
            n_fail++;
            $display("FAIL hold_next_done: stall=%b req=%b addr=%h rdata=%h, required 0 1 80000014 0badcafe",
                     cpu_stall, data_req, data_addr, cpu_rdata);
        end
        step();
        idle_inputs();
        step();
    endtask

    // Slow addr_ok: request fields stay stable, and a spurious data_ok is ignored.
    task automatic test_addr_wait();
        cpu_en    = 1'b1;
        cpu_addr  = 32'h8000_0020;
        cpu_size  = 2'd1;
        cpu_sel   = 4'b0011;
        cpu_wdata = 32'hA5A5_C3C3;
        step();
        // Inputs on the CPU side change while the access is in flight.
        // The bus side must keep the latched values.
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_size  = 2'd2;
        cpu_sel   = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            data_data_ok = (i == 2);
            @(negedge clk);
            n_chk++;
            if ({cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb} !==
                {1'b1, 1'b1, 1'b1, 2'd1, 32'h8000_0020, 32'hA5A5_C3C3, 4'b0011}) begin
                n_fail++;
                $display("FAIL wait_c%0d: stall=%b req=%b wr=%b size=%0d addr=%h wdata=%h wstrb=%b, required 1 1 1 1 80000020 a5a5c3c3 0011",
                         i, cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb);
            end
            step();
        end
        data_data_ok = 1'b0;
        data_addr_ok = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL wait_accept: stall/req=%b, required 11", {cpu_stall, data_req});
        end
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_done: stall/req=%b, required 00", {cpu_stall, data_req});
        end
        step();
        idle_inputs();
        step();
    endtask

    // Reset while waiting for data_ok; a late data_ok must be ignored afterward.
    task automatic test_reset_mid();
        cpu_en    = 1'b1;
        cpu_addr  = 32'h8000_0042;
        cpu_size  = 2'd0;
        cpu_sel   = 4'b0100;
        cpu_wdata = 32'h7777_7777;
        step();
        data_addr_ok = 1'b1;
        step();                                // now in DATA
        data_addr_ok = 1'b0;
        resetn       = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cpu_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: stall=%b, required 1", cpu_stall);
        end
        step();
        resetn       = 1'b1;
        cpu_en       = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, cpu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_after: stall=%b req=%b wr=%b size=%0d addr=%h wdata=%h wstrb=%b rdata=%h, all required 0",
                     cpu_stall, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, cpu_rdata);
        end
        step();
        data_data_ok = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({cpu_stall, data_req, cpu_rdata} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_late: stall=%b req=%b rdata=%h, required 0 0 00000000", cpu_stall, data_req, cpu_rdata);
        end
        step();
        idle_inputs();
    endtask

    // Stall counter after two runs of the word-load scenario (3 stall cycles each).
    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
`ifdef DSRAM_STALL_CNT_EN
        exp_cnt = 32'd6;
`else
        exp_cnt = 32'd0;
`endif
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        test_word_load();
        test_word_load();
        @(negedge clk);
        n_chk++;
        if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_cnt: %0d, required %0d", stall_cnt, exp_cnt);
        end
        step();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_word_load();
        test_byte_store();
        test_hold();
        test_addr_wait();
        test_reset_mid();
        test_stall_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
